// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, widths and region type.
// Imported by the axis counter, the output bundle interface and the top.
package vga_timing_pkg;

   localparam int DEF_H_ACT  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_ACT  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   localparam int DEF_H_TOT =
      DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
   localparam int DEF_V_TOT =
      DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

   localparam int CNT_W      = 11;
   localparam int XY_W       = 10;
   localparam int DEF_ADDR_W = 19;

   typedef enum logic [1:0] {
      SYNC,
      BPORCH,
      ACTIVE,
      FPORCH
   } rgn_e;

   function automatic logic in_win(
      input logic [CNT_W-1:0] c,
      input logic [CNT_W-1:0] lo,
      input logic [CNT_W-1:0] len
   );
      return (c >= lo) && (c < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster output bundle (sync, blank, coords, address, pulses).
// master = timing generator, slave = pixel-fetch/ROM stage.
interface vga_timing_gen_if
   import vga_timing_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              oHS;
   logic              oVS;
   logic              oBLANK_n;
   logic [XY_W-1:0]   oX;
   logic [XY_W-1:0]   oY;
   logic [ADDR_W-1:0] oADDR;
   logic              oLINE_START;
   logic              oFRAME_START;

   modport master (
      output oHS, oVS, oBLANK_n, oX, oY,
      output oADDR, oLINE_START, oFRAME_START
   );

   modport slave (
      input oHS, oVS, oBLANK_n, oX, oY,
      input oADDR, oLINE_START, oFRAME_START
   );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; counts 0..lim when en, decodes region.
// Ports: iVGA_CLK, iRST_n, en, lim in; cnt, wrap (en at lim), rgn out.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int W        = CNT_W,
   parameter int SYNC_LEN = DEF_H_SYNC,
   parameter int BP_LEN   = DEF_H_BP,
   parameter int ACT_LEN  = DEF_H_ACT
) (
   input  logic         iVGA_CLK,
   input  logic         iRST_n,
   input  logic         en,
   input  logic [W-1:0] lim,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output rgn_e         rgn
);
   localparam logic [W-1:0] B_SYNC = W'(SYNC_LEN);
   localparam logic [W-1:0] B_BP   = W'(SYNC_LEN + BP_LEN);
   localparam logic [W-1:0] B_ACT  = W'(SYNC_LEN + BP_LEN + ACT_LEN);
   localparam logic [W-1:0] ONE    = W'(1);

   assign wrap = en && (cnt == lim);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n)
         cnt <= '0;
      else if (en)
         cnt <= wrap ? '0 : cnt + ONE;
   end

   always_comb begin
      rgn = FPORCH;
      if (cnt < B_SYNC)
         rgn = SYNC;
      else if (cnt < B_BP)
         rgn = BPORCH;
      else if (cnt < B_ACT)
         rgn = ACTIVE;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing, coordinates and frame address.
// Ports: iVGA_CLK, iRST_n; vga (master) carries HS/VS/BLANK_n/X/Y/ADDR/pulses.
// VGA_TIMING_PREFETCH_EN: X/Y/ADDR lead sync/blank/pulses by one clock.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACT    = DEF_H_ACT,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACT    = DEF_V_ACT,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic             iVGA_CLK,
   input  logic             iRST_n,
   vga_timing_gen_if.master vga
);
   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

   localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_OFS = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] V_OFS = CNT_W'(V_SYNC + V_BP);

   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACT * V_ACT - 1);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             v_wrap;
   rgn_e             h_rgn;
   rgn_e             v_rgn;

   vga_axis_counter #(
      .W(CNT_W), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .ACT_LEN(H_ACT)
   ) u_h (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .en       (1'b1),
      .lim      (H_LIM),
      .cnt      (h_cnt),
      .wrap     (h_wrap),
      .rgn      (h_rgn)
   );

   vga_axis_counter #(
      .W(CNT_W), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .ACT_LEN(V_ACT)
   ) u_v (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .en       (h_wrap),
      .lim      (V_LIM),
      .cnt      (v_cnt),
      .wrap     (v_wrap),
      .rgn      (v_rgn)
   );

   logic act;
   logic first_col;

   assign act       = (h_rgn == ACTIVE) && (v_rgn == ACTIVE);
   assign first_col = act && (h_cnt == H_OFS);

   // Data path position: either the current counters or their next value.
   logic [CNT_W-1:0] h_d;
   logic [CNT_W-1:0] v_d;
   logic             act_d;

`ifdef VGA_TIMING_PREFETCH_EN
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   logic [CNT_W-1:0] h_la;
   logic [CNT_W-1:0] v_la;

   always_comb begin
      h_la = h_wrap ? '0 : h_cnt + C_ONE;
      v_la = v_cnt;
      if (h_wrap)
         v_la = v_wrap ? '0 : v_cnt + C_ONE;
   end

   assign h_d   = h_la;
   assign v_d   = v_la;
   assign act_d = in_win(h_la, H_OFS, CNT_W'(H_ACT)) &&
                  in_win(v_la, V_OFS, CNT_W'(V_ACT));
`else
   assign h_d   = h_cnt;
   assign v_d   = v_cnt;
   assign act_d = act;
`endif

   // pix is the address of the next active pixel; it is rewound on the
   // last raster position so it reads 0 before the next frame begins.
   logic [ADDR_W-1:0] pix;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vga.oHS          <= ~SYNC_POL;
         vga.oVS          <= ~SYNC_POL;
         vga.oBLANK_n     <= 1'b0;
         vga.oX           <= '0;
         vga.oY           <= '0;
         vga.oADDR        <= '0;
         vga.oLINE_START  <= 1'b0;
         vga.oFRAME_START <= 1'b0;
         pix              <= '0;
      end else begin
         vga.oHS          <= (h_rgn == SYNC) ? SYNC_POL : ~SYNC_POL;
         vga.oVS          <= (v_rgn == SYNC) ? SYNC_POL : ~SYNC_POL;
         vga.oBLANK_n     <= act;
         vga.oLINE_START  <= first_col;
         vga.oFRAME_START <= first_col && (v_cnt == V_OFS);
         if (act_d) begin
            vga.oX    <= XY_W'(h_d - H_OFS);
            vga.oY    <= XY_W'(v_d - V_OFS);
            vga.oADDR <= pix;
            if (pix != A_LAST)
               pix <= pix + A_ONE;
         end
         if (v_wrap)
            pix <= '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default and small-raster DUTs (both sync polarities)
// against a position-arithmetic raster model, with random mid-frame resets.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

`ifdef VGA_TIMING_PREFETCH_EN
   localparam bit PREF = 1'b1;
`else
   localparam bit PREF = 1'b0;
`endif

   localparam int ND = 3;

   typedef struct {
      int hs, hb, ha, hf, vs, vb, va, vf;
      bit pol;
   } cfg_t;

   typedef struct {
      bit hs, vs, bl, ls, fs, dact;
      int x, y;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.ADDR_W(19)) if0 ();
   vga_timing_gen_if #(.ADDR_W(8))  if1 ();
   vga_timing_gen_if #(.ADDR_W(8))  if2 ();

   vga_timing_gen #(
      .SYNC_POL(1'b0), .ADDR_W(19)
   ) u_def (
      .iVGA_CLK(clk), .iRST_n(rst_n), .vga(if0)
   );

   vga_timing_gen #(
      .H_ACT(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACT(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b0), .ADDR_W(8)
   ) u_sm0 (
      .iVGA_CLK(clk), .iRST_n(rst_n), .vga(if1)
   );

   vga_timing_gen #(
      .H_ACT(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACT(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b1), .ADDR_W(8)
   ) u_sm1 (
      .iVGA_CLK(clk), .iRST_n(rst_n), .vga(if2)
   );

   logic o_hs[ND], o_vs[ND], o_bl[ND], o_ls[ND], o_fs[ND];
   int   o_x[ND], o_y[ND], o_ad[ND];

   assign o_hs[0] = if0.oHS;
   assign o_vs[0] = if0.oVS;
   assign o_bl[0] = if0.oBLANK_n;
   assign o_ls[0] = if0.oLINE_START;
   assign o_fs[0] = if0.oFRAME_START;
   assign o_x[0]  = 32'(if0.oX);
   assign o_y[0]  = 32'(if0.oY);
   assign o_ad[0] = 32'(if0.oADDR);

   assign o_hs[1] = if1.oHS;
   assign o_vs[1] = if1.oVS;
   assign o_bl[1] = if1.oBLANK_n;
   assign o_ls[1] = if1.oLINE_START;
   assign o_fs[1] = if1.oFRAME_START;
   assign o_x[1]  = 32'(if1.oX);
   assign o_y[1]  = 32'(if1.oY);
   assign o_ad[1] = 32'(if1.oADDR);

   assign o_hs[2] = if2.oHS;
   assign o_vs[2] = if2.oVS;
   assign o_bl[2] = if2.oBLANK_n;
   assign o_ls[2] = if2.oLINE_START;
   assign o_fs[2] = if2.oFRAME_START;
   assign o_x[2]  = 32'(if2.oX);
   assign o_y[2]  = 32'(if2.oY);
   assign o_ad[2] = 32'(if2.oADDR);

   cfg_t cfg[ND];
   int   mk[ND];
   int   hx[ND], hy[ND], hadr[ND];

   int n_chk = 0;
   int n_err = 0;
   int cur   = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL dut%0d %s: got %0d, expected %0d (t=%0t)",
                  cur, tag, got, exp, $time);
      end
   endtask

   // Clock k after reset release shows the decode of raster position k-1;
   // with prefetch the data outputs show position k instead.
   function automatic exp_t model(input cfg_t c, input int k);
      exp_t e;
      int ht, tot, p, h, v, pd, hd, vd, ho, vo;
      ht  = c.hs + c.hb + c.ha + c.hf;
      tot = ht * (c.vs + c.vb + c.va + c.vf);
      ho  = c.hs + c.hb;
      vo  = c.vs + c.vb;
      p   = (k - 1) % tot;
      h   = p % ht;
      v   = p / ht;
      e.hs = (h < c.hs);
      e.vs = (v < c.vs);
      e.bl = (h >= ho) && (h < ho + c.ha) && (v >= vo) && (v < vo + c.va);
      e.ls = e.bl && (h == ho);
      e.fs = e.ls && (v == vo);
      pd = PREF ? (k % tot) : p;
      hd = pd % ht;
      vd = pd / ht;
      e.dact = (hd >= ho) && (hd < ho + c.ha) &&
               (vd >= vo) && (vd < vo + c.va);
      e.x = hd - ho;
      e.y = vd - vo;
      return e;
   endfunction

   initial forever begin
      exp_t e;
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) begin
            mk[d] = 0;
            hx[d] = 0;
            hy[d] = 0;
            hadr[d] = 0;
         end else begin
            mk[d] = mk[d] + 1;
            e = model(cfg[d], mk[d]);
            if (e.dact) begin
               hx[d] = e.x;
               hy[d] = e.y;
               hadr[d] = e.y * cfg[d].ha + e.x;
            end
         end
      end
   end

   task automatic cmp_all();
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         cur = d;
         if (!rst_n || mk[d] == 0) begin
            check("rst_hs",   o_hs[d], !cfg[d].pol);
            check("rst_vs",   o_vs[d], !cfg[d].pol);
            check("rst_blank", o_bl[d], 0);
            check("rst_ls",   o_ls[d], 0);
            check("rst_fs",   o_fs[d], 0);
            check("rst_x",    o_x[d], 0);
            check("rst_y",    o_y[d], 0);
            check("rst_addr", o_ad[d], 0);
         end else begin
            e = model(cfg[d], mk[d]);
            check("hs", o_hs[d], e.hs ? cfg[d].pol : !cfg[d].pol);
            check("vs", o_vs[d], e.vs ? cfg[d].pol : !cfg[d].pol);
            check("blank_n", o_bl[d], e.bl);
            check("line_start", o_ls[d], e.ls);
            check("frame_start", o_fs[d], e.fs);
            check("x", o_x[d], hx[d]);
            check("y", o_y[d], hy[d]);
            if (e.dact)
               check("addr", o_ad[d], hadr[d]);
         end
      end
   endtask

   int rise_k = -1;
   bit bl0_q  = 1'b0;
   bit agg_v  = 1'b0;
   int agg_c, agg_b, agg_l;

   task automatic frame_stats();
      int tot1;
      tot1 = (cfg[1].hs + cfg[1].hb + cfg[1].ha + cfg[1].hf) *
             (cfg[1].vs + cfg[1].vb + cfg[1].va + cfg[1].vf);
      if (rst_n && o_bl[0] && !bl0_q && rise_k < 0)
         rise_k = mk[0];
      bl0_q = o_bl[0];
      if (!rst_n || mk[1] == 0) begin
         agg_v = 1'b0;
      end else begin
         if (o_fs[1]) begin
            if (agg_v) begin
               cur = 1;
               check("frame_len", agg_c, tot1);
               check("frame_blank_hi", agg_b, cfg[1].ha * cfg[1].va);
               check("frame_lines", agg_l, cfg[1].va);
            end
            agg_v = 1'b1;
            agg_c = 0;
            agg_b = 0;
            agg_l = 0;
         end
         agg_c += 1;
         agg_b += int'(o_bl[1]);
         agg_l += int'(o_ls[1]);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         cmp_all();
         frame_stats();
      end
   end

   initial begin
      int small_frm;
      cfg[0] = '{hs:96, hb:48, ha:640, hf:16,
                 vs:2, vb:33, va:480, vf:10, pol:1'b0};
      cfg[1] = '{hs:4, hb:5, ha:16, hf:3,
                 vs:2, vb:3, va:10, vf:2, pol:1'b0};
      cfg[2] = '{hs:4, hb:5, ha:16, hf:3,
                 vs:2, vb:3, va:10, vf:2, pol:1'b1};
      small_frm = 28 * 17;
      chk_en = 1'b1;

      repeat (10) @(negedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 30000 && rise_k < 0; i++)
         @(negedge clk);
      #1;
      cur = 0;
      check("first_blank_clk", rise_k,
            (cfg[0].vs + cfg[0].vb) * DEF_H_TOT +
            cfg[0].hs + cfg[0].hb + 1);

      repeat (3 * small_frm + 60) @(negedge clk);

      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(1000, 40)) @(negedge clk);
         #2 rst_n = 1'b0;
         #1 cmp_all();
         repeat ($urandom_range(4, 1)) @(negedge clk);
         #2 rst_n = 1'b1;
      end

      repeat (3 * small_frm + 60) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
